// File: rtl/csr_file_pkg.sv
// Shared CSR addresses, field positions, writable-bit masks and reset values for csr_file.
// The optional timer block is selected by the CSR_TIMER_EN macro.
package csr_file_pkg;

   localparam logic [13:0] CSR_CRMD   = 14'h00;
   localparam logic [13:0] CSR_PRMD   = 14'h01;
   localparam logic [13:0] CSR_ECFG   = 14'h04;
   localparam logic [13:0] CSR_ESTAT  = 14'h05;
   localparam logic [13:0] CSR_ERA    = 14'h06;
   localparam logic [13:0] CSR_BADV   = 14'h07;
   localparam logic [13:0] CSR_EENTRY = 14'h0C;
   localparam logic [13:0] CSR_SAVE0  = 14'h30;
   localparam logic [13:0] CSR_SAVE1  = 14'h31;
   localparam logic [13:0] CSR_SAVE2  = 14'h32;
   localparam logic [13:0] CSR_SAVE3  = 14'h33;
   localparam logic [13:0] CSR_TID    = 14'h40;
   localparam logic [13:0] CSR_TCFG   = 14'h41;
   localparam logic [13:0] CSR_TVAL   = 14'h42;
   localparam logic [13:0] CSR_TICLR  = 14'h44;

   localparam int CRMD_IE       = 2;
   localparam int TCFG_EN       = 0;
   localparam int TCFG_PERIODIC = 1;

   // Bits that software may change in each register; everything else is read-only or reserved.
   localparam logic [31:0] CRMD_WMASK   = 32'h0000_000F;
   localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
   localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
   localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
   localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

   localparam logic [5:0] ECODE_ADE     = 6'h08;
   localparam logic [5:0] ECODE_ALE     = 6'h09;
   localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
   localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

   localparam logic [31:0] CRMD_RST = 32'h0000_0008;

   function automatic logic [31:0] csr_merge(input logic [31:0] old_value,
                                             input logic [31:0] wmask,
                                             input logic [31:0] wvalue,
                                             input logic [31:0] writable);
      logic [31:0] eff;
      eff = wmask & writable;
      return (old_value & ~eff) | (wvalue & eff);
   endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable-counter timer: TID, TCFG, TVAL and the sticky timer interrupt TI with its TICLR clear.
// Instantiated by csr_file only when CSR_TIMER_EN is defined.
module csr_timer
   import csr_file_pkg::*;
#(
   parameter int TIMER_W = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        csr_wr,
   input  logic [13:0] csr_num,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wvalue,
   output logic [31:0] rvalue,
   output logic        ti
);

   logic [31:0]        tid;
   logic [31:0]        tcfg;
   logic [TIMER_W-1:0] tval;
   logic [31:0]        tcfg_new;
   logic               tcfg_wr;
   logic               ti_set;
   logic               ti_clr;

   assign tcfg_new = csr_merge(tcfg, csr_wmask, csr_wvalue, FULL_WMASK);
   assign tcfg_wr  = csr_wr && (csr_num == CSR_TCFG);
   assign ti_set   = !tcfg_wr && tcfg[TCFG_EN] && (tval == TIMER_W'(1));
   assign ti_clr   = csr_wr && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0];

   // A TCFG write reloads the counter; otherwise it counts down and, if periodic, reloads at zero.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tid  <= '0;
         tcfg <= '0;
         tval <= '1;
         ti   <= 1'b0;
      end else begin
         if (csr_wr && (csr_num == CSR_TID))
            tid <= csr_merge(tid, csr_wmask, csr_wvalue, FULL_WMASK);
         if (tcfg_wr) begin
            tcfg <= tcfg_new;
            tval <= {tcfg_new[TIMER_W-1:2], 2'b00};
         end else if (tcfg[TCFG_EN] && (tval != '0)) begin
            tval <= tval - TIMER_W'(1);
         end else if (tcfg[TCFG_EN] && tcfg[TCFG_PERIODIC]) begin
            tval <= {tcfg[TIMER_W-1:2], 2'b00};
         end
         if (ti_set)
            ti <= 1'b1;
         else if (ti_clr)
            ti <= 1'b0;
      end
   end

   always_comb begin
      rvalue = '0;
      case (csr_num)
         CSR_TID:  rvalue = tid;
         CSR_TCFG: rvalue = tcfg;
         CSR_TVAL: rvalue = 32'(tval);
         default:  rvalue = '0;
      endcase
   end

endmodule

// File: rtl/csr_file.sv
// Architectural CSR file: combinational reads, masked writes, exception/ertn state updates, interrupts.
// Define CSR_TIMER_EN to include the TID/TCFG/TVAL/TICLR timer block.
module csr_file
   import csr_file_pkg::*;
#(
   parameter int TIMER_W = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        csr_re,
   input  logic [13:0] csr_num,
   output logic [31:0] csr_rvalue,
   input  logic        csr_we,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wvalue,
   input  logic        wb_ex,
   input  logic        ertn_flush,
   input  logic [31:0] wb_pc,
   input  logic [5:0]  wb_ecode,
   input  logic [8:0]  wb_esubcode,
   input  logic [31:0] wb_vaddr,
   input  logic        current_exc_fetch,
   input  logic [7:0]  hw_int_in,
   input  logic        ipi_int_in,
   output logic        has_int,
   output logic [31:0] ex_entry,
   output logic [31:0] ertn_entry
);

   logic [31:0] crmd, prmd, ecfg, era, badv, eentry;
   logic [31:0] save0, save1, save2, save3;
   logic [1:0]  is_sw;
   logic [7:0]  is_hw;
   logic        is_ipi;
   logic [5:0]  ecode;
   logic [8:0]  esubcode;
   logic [12:0] estat_is;
   logic [31:0] timer_rvalue;
   logic        ti;
   logic        csr_wr;
   logic        unused_re;

   // The read port is always live, so the read qualifier carries no information here.
   assign unused_re = csr_re;

   // An exception committing in the same cycle squashes the software write.
   assign csr_wr = csr_we && !wb_ex;

`ifdef CSR_TIMER_EN
   csr_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .csr_wr     (csr_wr),
      .csr_num    (csr_num),
      .csr_wmask  (csr_wmask),
      .csr_wvalue (csr_wvalue),
      .rvalue     (timer_rvalue),
      .ti         (ti)
   );
`else
   assign timer_rvalue = '0;
   assign ti           = 1'b0;
`endif

   assign estat_is   = {is_ipi, ti, 1'b0, is_hw, is_sw};
   assign has_int    = |(estat_is & ecfg[12:0]) & crmd[CRMD_IE];
   assign ex_entry   = eentry;
   assign ertn_entry = era;

   // Software writes first; exception or ertn updates assigned later override them on the same edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         crmd     <= CRMD_RST;
         prmd     <= '0;
         ecfg     <= '0;
         era      <= '0;
         badv     <= '0;
         eentry   <= '0;
         save0    <= '0;
         save1    <= '0;
         save2    <= '0;
         save3    <= '0;
         is_sw    <= '0;
         is_hw    <= '0;
         is_ipi   <= 1'b0;
         ecode    <= '0;
         esubcode <= '0;
      end else begin
         if (csr_wr) begin
            case (csr_num)
               CSR_CRMD:   crmd   <= csr_merge(crmd, csr_wmask, csr_wvalue, CRMD_WMASK);
               CSR_PRMD:   prmd   <= csr_merge(prmd, csr_wmask, csr_wvalue, PRMD_WMASK);
               CSR_ECFG:   ecfg   <= csr_merge(ecfg, csr_wmask, csr_wvalue, ECFG_WMASK);
               CSR_ESTAT:  is_sw  <= (is_sw & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
               CSR_ERA:    era    <= csr_merge(era, csr_wmask, csr_wvalue, FULL_WMASK);
               CSR_BADV:   badv   <= csr_merge(badv, csr_wmask, csr_wvalue, FULL_WMASK);
               CSR_EENTRY: eentry <= csr_merge(eentry, csr_wmask, csr_wvalue, EENTRY_WMASK);
               CSR_SAVE0:  save0  <= csr_merge(save0, csr_wmask, csr_wvalue, FULL_WMASK);
               CSR_SAVE1:  save1  <= csr_merge(save1, csr_wmask, csr_wvalue, FULL_WMASK);
               CSR_SAVE2:  save2  <= csr_merge(save2, csr_wmask, csr_wvalue, FULL_WMASK);
               CSR_SAVE3:  save3  <= csr_merge(save3, csr_wmask, csr_wvalue, FULL_WMASK);
               default: ;
            endcase
         end
         is_hw  <= hw_int_in;
         is_ipi <= ipi_int_in;
         if (wb_ex) begin
            prmd[2:0] <= crmd[2:0];
            crmd[2:0] <= 3'b000;
            ecode     <= wb_ecode;
            esubcode  <= wb_esubcode;
            era       <= wb_pc;
            if ((wb_ecode == ECODE_ADE) || (wb_ecode == ECODE_ALE))
               badv <= current_exc_fetch ? wb_pc : wb_vaddr;
         end else if (ertn_flush) begin
            crmd[2:0] <= prmd[2:0];
         end
      end
   end

   always_comb begin
      csr_rvalue = '0;
      case (csr_num)
         CSR_CRMD:   csr_rvalue = crmd;
         CSR_PRMD:   csr_rvalue = prmd;
         CSR_ECFG:   csr_rvalue = ecfg;
         CSR_ESTAT:  csr_rvalue = {1'b0, esubcode, ecode, 3'b000, estat_is};
         CSR_ERA:    csr_rvalue = era;
         CSR_BADV:   csr_rvalue = badv;
         CSR_EENTRY: csr_rvalue = eentry;
         CSR_SAVE0:  csr_rvalue = save0;
         CSR_SAVE1:  csr_rvalue = save1;
         CSR_SAVE2:  csr_rvalue = save2;
         CSR_SAVE3:  csr_rvalue = save3;
         default:    csr_rvalue = timer_rvalue;
      endcase
   end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios followed by random traffic against a table-driven model.
// Timer expectations follow whether CSR_TIMER_EN is defined for the build.
module tb_csr_file;
   import csr_file_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        csr_re = 1'b1;
   logic [13:0] csr_num = '0;
   logic        csr_we = 1'b0;
   logic [31:0] csr_wmask = '0;
   logic [31:0] csr_wvalue = '0;
   logic        wb_ex = 1'b0;
   logic        ertn_flush = 1'b0;
   logic [31:0] wb_pc = '0;
   logic [5:0]  wb_ecode = '0;
   logic [8:0]  wb_esubcode = '0;
   logic [31:0] wb_vaddr = '0;
   logic        current_exc_fetch = 1'b0;
   logic [7:0]  hw_int_in = '0;
   logic        ipi_int_in = 1'b0;
   logic [31:0] csr_rvalue;
   logic        has_int;
   logic [31:0] ex_entry;
   logic [31:0] ertn_entry;

   int total = 0;
   int bad = 0;

   // Model state: plain registers live in an address-indexed table; ESTAT and the counter are kept as fields.
   logic [31:0] m [int];
   logic [1:0]  mSw;
   logic [7:0]  mHw;
   logic        mIpi;
   logic [5:0]  mEcode;
   logic [8:0]  mEsub;
   logic [31:0] mTval;
   logic        mTi;

   csr_file dut (
      .clk               (clk),
      .resetn            (resetn),
      .csr_re            (csr_re),
      .csr_num           (csr_num),
      .csr_rvalue        (csr_rvalue),
      .csr_we            (csr_we),
      .csr_wmask         (csr_wmask),
      .csr_wvalue        (csr_wvalue),
      .wb_ex             (wb_ex),
      .ertn_flush        (ertn_flush),
      .wb_pc             (wb_pc),
      .wb_ecode          (wb_ecode),
      .wb_esubcode       (wb_esubcode),
      .wb_vaddr          (wb_vaddr),
      .current_exc_fetch (current_exc_fetch),
      .hw_int_in         (hw_int_in),
      .ipi_int_in        (ipi_int_in),
      .has_int           (has_int),
      .ex_entry          (ex_entry),
      .ertn_entry        (ertn_entry)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] writableOf(int a);
      case (a)
         'h00: return 32'h0000_000F;
         'h01: return 32'h0000_0007;
         'h04: return 32'h0000_1BFF;
         'h0C: return 32'hFFFF_FFC0;
         'h06, 'h07, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41: return 32'hFFFF_FFFF;
         default: return 32'h0;
      endcase
   endfunction

   function automatic void modelReset();
      m.delete();
      m['h00] = 32'h8;
      m['h01] = 0; m['h04] = 0; m['h06] = 0; m['h07] = 0; m['h0C] = 0;
      m['h30] = 0; m['h31] = 0; m['h32] = 0; m['h33] = 0;
`ifdef CSR_TIMER_EN
      m['h40] = 0; m['h41] = 0;
`endif
      mSw = 0; mHw = 0; mIpi = 0; mEcode = 0; mEsub = 0;
      mTval = 32'hFFFF_FFFF;
      mTi = 0;
   endfunction

   function automatic logic [31:0] modelRead(int a);
      case (a)
         'h05: return {1'b0, mEsub, mEcode, 3'b000, mIpi, mTi, 1'b0, mHw, mSw};
`ifdef CSR_TIMER_EN
         'h42: return mTval;
`endif
         'h44: return 32'h0;
         default: return m.exists(a) ? m[a] : 32'h0;
      endcase
   endfunction

   function automatic logic modelHasInt();
      logic [31:0] estat;
      logic [31:0] lie;
      estat = modelRead('h05);
      lie = m['h04];
      return (|(estat[12:0] & lie[12:0])) & m['h00][2];
   endfunction

   // Next-state of the architectural registers from the inputs presented before the coming edge.
   function automatic void modelStep();
      logic [31:0] old [int];
      int          a;
      bit          wr;
      logic [31:0] eff;
      if (!resetn) begin
         modelReset();
         return;
      end
      old = m;
      a = int'(csr_num);
      wr = csr_we && !wb_ex;
      eff = csr_wmask & writableOf(a);
      if (wr && m.exists(a)) m[a] = (old[a] & ~eff) | (csr_wvalue & eff);
      if (wr && a == 'h05) mSw = (mSw & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
`ifdef CSR_TIMER_EN
      begin
         bit setTi;
         bit clrTi;
         setTi = 0;
         clrTi = wr && a == 'h44 && csr_wvalue[0] && csr_wmask[0];
         if (wr && a == 'h41) mTval = {m['h41][31:2], 2'b00};
         else if (old['h41][0] && mTval != 0) begin
            if (mTval == 1) setTi = 1;
            mTval = mTval - 1;
         end else if (old['h41][0] && old['h41][1]) mTval = {old['h41][31:2], 2'b00};
         if (setTi) mTi = 1;
         else if (clrTi) mTi = 0;
      end
`endif
      if (wb_ex) begin
         m['h01] = {29'b0, old['h00][2:0]};
         m['h00] = old['h00] & ~32'h7;
         mEcode = wb_ecode;
         mEsub = wb_esubcode;
         m['h06] = wb_pc;
         if (wb_ecode == 6'h08 || wb_ecode == 6'h09) m['h07] = current_exc_fetch ? wb_pc : wb_vaddr;
      end else if (ertn_flush) begin
         m['h00] = (m['h00] & ~32'h7) | (old['h01] & 32'h7);
      end
      mHw = hw_int_in;
      mIpi = ipi_int_in;
   endfunction

   task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit rst_n, input bit we, input logic [13:0] num,
                                input logic [31:0] mask, input logic [31:0] val,
                                input bit ex, input bit er);
      resetn = rst_n;
      csr_we = we;
      csr_num = num;
      csr_wmask = mask;
      csr_wvalue = val;
      wb_ex = ex;
      ertn_flush = er;
      modelStep();
      @(posedge clk);
      #1;
      csr_we = 1'b0;
      wb_ex = 1'b0;
      ertn_flush = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [13:0] addr);
      csr_num = addr;
      #1;
      compare(tag, csr_rvalue, modelRead(int'(addr)));
      compare({tag, "_has_int"}, {31'b0, has_int}, {31'b0, modelHasInt()});
      compare({tag, "_ex_entry"}, ex_entry, m['h0C]);
      compare({tag, "_ertn_entry"}, ertn_entry, m['h06]);
   endtask

   initial begin
      int addrs [$] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h07, 'h0C, 'h30, 'h31, 'h32, 'h33,
                        'h40, 'h41, 'h42, 'h44, 'h10};

      // Reset and reset values
      applyStimulus(0, 0, CSR_CRMD, 0, 0, 0, 0);
      applyStimulus(0, 0, CSR_CRMD, 0, 0, 0, 0);
      compare("crmd_reset_const", csr_rvalue, 32'h0000_0008);
      checkOutput("crmd_reset", CSR_CRMD);
      checkOutput("tval_reset", CSR_TVAL);
      applyStimulus(1, 0, CSR_CRMD, 0, 0, 0, 0);
      checkOutput("estat_reset", CSR_ESTAT);

      // Enable IE, then an ALE exception from a data access, then return
      applyStimulus(1, 1, CSR_CRMD, 32'h4, 32'h7, 0, 0);
      checkOutput("crmd_ie_set", CSR_CRMD);
      wb_pc = 32'h1C00_0100;
      wb_vaddr = 32'h1234_5671;
      wb_ecode = ECODE_ALE;
      wb_esubcode = ESUBCODE_ADEM;
      current_exc_fetch = 1'b0;
      applyStimulus(1, 0, CSR_CRMD, 0, 0, 1, 0);
      checkOutput("ex_prmd", CSR_PRMD);
      checkOutput("ex_crmd", CSR_CRMD);
      checkOutput("ex_era", CSR_ERA);
      checkOutput("ex_badv", CSR_BADV);
      compare("ex_badv_const", csr_rvalue, 32'h1234_5671);
      checkOutput("ex_estat", CSR_ESTAT);
      applyStimulus(1, 0, CSR_CRMD, 0, 0, 0, 1);
      checkOutput("ertn_crmd", CSR_CRMD);

      // Fetch-side ADE takes the PC as BADV; ertn racing an exception loses
      wb_ecode = ECODE_ADE;
      wb_esubcode = ESUBCODE_ADEF;
      wb_pc = 32'h1C00_0200;
      current_exc_fetch = 1'b1;
      applyStimulus(1, 0, CSR_CRMD, 0, 0, 1, 1);
      checkOutput("ade_badv", CSR_BADV);
      checkOutput("ex_ertn_crmd", CSR_CRMD);

      // ertn racing a CRMD write: ertn owns PLV/IE
      applyStimulus(1, 1, CSR_CRMD, 32'h7, 32'h3, 0, 1);
      checkOutput("ertn_vs_write", CSR_CRMD);

      // EENTRY low bits are read as zero
      applyStimulus(1, 1, CSR_EENTRY, 32'hFFFF_FFFF, 32'h1C00_807F, 0, 0);
      checkOutput("eentry", CSR_EENTRY);

      // Periodic timer: InitVal=4, En, Periodic
      applyStimulus(1, 1, CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0013, 0, 0);
      checkOutput("tcfg_load", CSR_TVAL);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1, 0, CSR_TVAL, 0, 0, 0, 0);
         checkOutput("tval_count", CSR_TVAL);
      end
      checkOutput("ti_after_wrap", CSR_ESTAT);
      applyStimulus(1, 1, CSR_TICLR, 32'h1, 32'h1, 0, 0);
      checkOutput("ticlr", CSR_ESTAT);

      // Timer interrupt enabled through LIE and IE
      applyStimulus(1, 1, CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_0800, 0, 0);
      applyStimulus(1, 1, CSR_CRMD, 32'h4, 32'h4, 0, 0);
      for (int i = 0; i < 18; i++) applyStimulus(1, 0, CSR_ESTAT, 0, 0, 0, 0);
      checkOutput("has_int_ti", CSR_ESTAT);
      applyStimulus(1, 1, CSR_CRMD, 32'h4, 32'h0, 0, 0);
      checkOutput("has_int_ie_off", CSR_CRMD);

      // Exception squashes a simultaneous SAVE0 write
      applyStimulus(1, 1, CSR_SAVE0, 32'hFFFF_FFFF, 32'h0000_1111, 0, 0);
      wb_ecode = 6'h0B;
      applyStimulus(1, 1, CSR_SAVE0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1, 0);
      checkOutput("save0_squashed", CSR_SAVE0);

      // External interrupt sampling and ESTAT write protection
      hw_int_in = 8'h01;
      applyStimulus(1, 0, CSR_ESTAT, 0, 0, 0, 0);
      checkOutput("hw_int_is2", CSR_ESTAT);
      applyStimulus(1, 1, CSR_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      checkOutput("estat_wprot", CSR_ESTAT);
      checkOutput("unimpl_read", 14'h010);

      // Reset mid-count overrides a concurrent write
      applyStimulus(0, 1, CSR_SAVE0, 32'hFFFF_FFFF, 32'h5555_AAAA, 0, 0);
      checkOutput("rst_mid_save0", CSR_SAVE0);
      checkOutput("rst_mid_tval", CSR_TVAL);
      checkOutput("rst_mid_crmd", CSR_CRMD);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         int a;
         logic [31:0] val;
         logic [31:0] mask;
         a = addrs[$urandom_range(0, addrs.size() - 1)];
         val = $urandom;
         mask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
         if (a == 'h41) val = val & 32'h0000_003F;
         hw_int_in = 8'($urandom);
         ipi_int_in = 1'($urandom);
         wb_pc = $urandom;
         wb_vaddr = $urandom;
         wb_esubcode = 9'($urandom);
         current_exc_fetch = 1'($urandom);
         case ($urandom_range(0, 3))
            0: wb_ecode = ECODE_ADE;
            1: wb_ecode = ECODE_ALE;
            default: wb_ecode = 6'($urandom);
         endcase
         applyStimulus(1, 1'($urandom), 14'(a), mask, val,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
         checkOutput("rand", 14'(addrs[$urandom_range(0, addrs.size() - 1)]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/csr_file.md
# csr_file

Architectural control/status register file answering the write-back stage's CSR port. Serves combinational CSR reads and applies masked CSR writes, and performs the hardware state updates for exception commit (`wb_ex`) and `ertn` (`ertn_flush`). Owns the stable-counter timer and interrupt aggregation. Supplies `has_int`, the exception entry and the `ertn` return address to the fetch/decode logic.

## Interface
Parameters:
- `TIMER_W`, 32, width of TVAL/TCFG.InitVal datapath.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `csr_re`  in  1  read qualifier (informational; read path is always live).
- `csr_num`  in  14  CSR address for read and write.
- `csr_rvalue`  out  32  read data.
- `csr_we`  in  1  write enable.
- `csr_wmask`  in  32  per-bit write mask.
- `csr_wvalue`  in  32  write data.
- `wb_ex`  in  1  exception commits this cycle.
- `ertn_flush`  in  1  `ertn` commits this cycle.
- `wb_pc`  in  32  PC of the committing instruction.
- `wb_ecode`  in  6  exception code.
- `wb_esubcode`  in  9  exception subcode.
- `wb_vaddr`  in  32  faulting data address.
- `current_exc_fetch`  in  1  exception was raised at fetch; selects `wb_pc` for BADV.
- `hw_int_in`  in  8  external interrupt lines, level.
- `ipi_int_in`  in  1  inter-processor interrupt, level.
- `has_int`  out  1  enabled interrupt pending.
- `ex_entry`  out  32  EENTRY value.
- `ertn_entry`  out  32  ERA value.

## Operation
- Implemented CSRs:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3].
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[12:0], with bit 10 reserved at 0.
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22].
  - ERA 0x6, BADV 0x7, EENTRY 0xC (bits [5:0] read 0), SAVE0–3 0x30–0x33, TID 0x40.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only.
  - TICLR 0x44: reads 0.
- Unimplemented addresses read 0; writes to them are ignored.
- Write rule: `new = (old & ~wmask) | (wvalue & wmask)`, restricted to writable bits. Read-only and reserved bits are unaffected.
- ESTAT writable bits are IS[1:0] only.
- IS[9:2] is sampled from `hw_int_in` every cycle. IS[12] is sampled from `ipi_int_in`. IS[11] is the timer interrupt (TI), a sticky bit.
- On `wb_ex`:
  - PRMD.PPLV←CRMD.PLV, PRMD.PIE←CRMD.IE.
  - CRMD.PLV←0, CRMD.IE←0.
  - ESTAT.Ecode←`wb_ecode`, ESTAT.EsubCode←`wb_esubcode`.
  - ERA←`wb_pc`.
- BADV on `wb_ex` with ecode ADE (0x08) or ALE (0x09):
  - BADV←`wb_pc` if `current_exc_fetch`.
  - BADV←`wb_vaddr` otherwise.
- On `ertn_flush`: CRMD.PLV←PPLV, CRMD.IE←PIE.
- Simultaneous events:
  - `wb_ex` together with `csr_we`: the write is dropped.
  - `wb_ex` together with `ertn_flush`: `wb_ex` wins.
  - `ertn_flush` together with `csr_we` to CRMD: the ertn update wins.
- `has_int = |(ESTAT.IS[12:0] & ECFG.LIE[12:0]) & CRMD.IE`. It is combinational.
- `ex_entry` = EENTRY, `ertn_entry` = ERA, both combinational.
- Timer:
  - A TCFG write loads TVAL←{InitVal_new, 2'b00}.
  - Otherwise, if En and TVAL≠0: TVAL←TVAL−1.
  - When TVAL==1 while decrementing, TI←1 on the same edge.
  - If En, Periodic and TVAL==0: TVAL←{InitVal, 2'b00}.
  - If En, not Periodic and TVAL==0: TVAL holds at 0.
- TICLR write with `wvalue[0] & wmask[0]` clears TI. If a set and a clear occur in the same cycle, the set wins.

## Timing
- Reads are combinational in the same cycle. A write is visible on `csr_rvalue` the cycle after it commits. A read in the write cycle returns the old value.
- All state updates occur on the rising `clk` edge.
- Reset:
  - CRMD = 0x8 (DA=1).
  - PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0–3, TID, TCFG = 0.
  - TVAL = 0xFFFF_FFFF.
  - TI = 0.
- Output values in reset: `has_int` = 0, `ex_entry` = 0, `ertn_entry` = 0.
- Reset asserted mid-count restores the reset values on the next edge, overriding every other event.
- Interrupt latency: an input level change reaches IS on the next edge, and `has_int` the same cycle as IS.

## Configuration
- `CSR_TIMER_EN` defined: TID/TCFG/TVAL/TICLR and TI are implemented as above.
- `CSR_TIMER_EN` undefined: the timer registers are absent. Addresses 0x40–0x44 read 0 and writes to them are ignored. IS[11] is tied to 0. No counter logic is generated.

## Structure
- The shared header/package holds:
  - CSR address constants.
  - Field bit positions.
  - `ECODE_ADE`, `ECODE_ALE`, `ESUBCODE_*`.
  - Reset values.
- Natural sub-module: `csr_timer` (TCFG/TVAL/TI/TICLR logic). It is instantiated only under `CSR_TIMER_EN`.

## Test plan
- Reset, then read CRMD → 0x0000_0008. Read TVAL → 0xFFFF_FFFF (timer enabled).
- Write CRMD with wvalue=0x7, wmask=0x4; then `wb_ex` with ecode 0x09, pc 0x1C00_0100, vaddr 0x1234_5671, `current_exc_fetch`=0 → PRMD=0x4, CRMD.IE=0, ERA=0x1C00_0100, BADV=0x1234_5671, ESTAT[21:16]=0x09. Then `ertn_flush` → CRMD.IE=1.
- Write TCFG=0x0000_0013 (InitVal=4, En, Periodic) → TVAL=0x10, reaches 0 after 16 cycles with TI=1, reloads 0x10. TICLR write 1 → TI=0 next cycle.
- ECFG.LIE=0x800, CRMD.IE=1, TI set → `has_int`=1. CRMD.IE cleared → `has_int`=0.
- `wb_ex` and `csr_we` to SAVE0 (0xDEAD_BEEF) in the same cycle → SAVE0 unchanged.
- `hw_int_in`=0x01 → ESTAT.IS[2]=1 after one edge. A write to ESTAT with mask 0xFFFF_FFFF alters only IS[1:0].
